tile_output_buffer: RTL
=======================

# tile_output_buffer

Transmit-side counterpart of the tile input path. Accepts 32-bit AXI4-Stream words from the upscaler/DMA, unpacks them into bytes (LSB first), and drives a native 8-bit video bus with a generated raster: data, horizontal/vertical blanking flags, and data-enable. Sits between the output AXI4-Stream DMA and the video encoder pins. It flags underflow and frame-length mismatch as sticky status bits.

## Interface
- H_ACTIVE, 1440, active bytes per line (720 px YCbCr 4:2:2)
- H_BLANK, 276, blanking bytes per line
- V_ACTIVE, 480, active lines per frame
- V_BLANK, 45, blanking lines per frame
- BLANK_BYTE, 8'h10, byte driven on data_out outside active region and on underflow
- aclk  in  1  single clock for all logic; one clock domain
- aresetn  in  1  reset, asynchronous assert, active-low
- enable  in  1  run request; sampled on aclk
- s_axis_tdata  in  32  four bytes, byte 0 = bits [7:0] sent first
- s_axis_tvalid  in  1  AXI4-Stream valid
- s_axis_tready  out  1  AXI4-Stream ready
- s_axis_tlast  in  1  marks last word of a frame
- data_out  out  8  video byte
- hs_out  out  1  high during horizontal blanking
- vs_out  out  1  high during vertical blanking
- de_out  out  1  high when data_out carries stream data in the active region
- underflow  out  1  sticky: active byte needed, no word held
- frame_err  out  1  sticky: tlast not on the last word of a frame
- clear_status  in  1  synchronous pulse, clears underflow and frame_err

## Operation
- Constraint: H_ACTIVE*V_ACTIVE divisible by 4; H_TOTAL = H_ACTIVE+H_BLANK, V_TOTAL = V_ACTIVE+V_BLANK.
- States: IDLE, RUN. Reset -> IDLE. IDLE -> RUN when enable=1. RUN -> IDLE only at end of frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) with enable=0; the frame always completes.
- IDLE: h_cnt=v_cnt=0, tready=0, outputs at their reset values; the held word is kept.
- RUN: h_cnt increments every cycle and wraps at H_TOTAL-1 to 0, which increments v_cnt; v_cnt wraps at V_TOTAL-1.
- active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
- Unpacker: word register, byte_idx (0..3), word_valid. On an active cycle with word_valid, emit byte[byte_idx] and increment; at idx 3 clear word_valid, unless a new word is accepted in the same cycle.
- s_axis_tready = RUN && (!word_valid || (active && byte_idx==3)). A pass-through refill gives zero bubbles.
- Active cycle with !word_valid: emit BLANK_BYTE, de_out=0, set underflow. The raster does not stall, and the missed byte is skipped, not delayed.
- Word counter in RUN counts accepted words modulo H_ACTIVE*V_ACTIVE/4. frame_err sets if tlast=1 on a non-final word, or tlast=0 on the final word. Counter resets to 0 on entering RUN.
- Simultaneous clear_status and set event: set wins.

## Timing
- Reset values: data_out=BLANK_BYTE, hs_out=0, vs_out=0, de_out=0, s_axis_tready=0, underflow=0, frame_err=0; counters, byte_idx, and word_valid are 0.
- All outputs registered. Values for counter position (h,v) appear one cycle later, with data, hs, vs, and de aligned.
- Word handshake at cycle N: byte 0 can appear on data_out at N+2 (captured at N+1, registered out).
- Transfer occurs only on tvalid&&tready; tdata and tlast are sampled on that edge.
- Asynchronous reset mid-frame: immediate return to reset values; the held word is discarded.

## Structure
- Shared package video_pkg: BT.656 blank constant (8'h10), default NTSC raster constants, and the state enum {IDLE, RUN}.
- One natural sub-module, video_timing_gen: h/v counters plus active/hs/vs flags. The top level holds the unpacker, handshake, and status logic.

## Test plan
- Params H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, V_BLANK=2. Stream words 0x03020100..0x0F0E0D0C with tlast on the 4th word, tvalid held high -> data_out 00..07 on line 0 and 08..0F on line 1, de_out high 8 cycles per active line, no underflow or frame_err.
- Same parameters, tvalid dropped for 3 cycles mid-line 0 -> those bytes are 8'h10 with de_out=0, underflow=1 until clear_status.
- tlast asserted on word 2 of 4 -> frame_err=1; raster continues uninterrupted.
- enable deasserted mid-frame -> frame completes through v_cnt=3, then IDLE with tready=0 and hs/vs/de=0.
- aresetn pulsed low mid-line -> all outputs return to reset values in the same cycle; the first byte after re-enable is byte 0 of the next accepted word.
- Check that hs_out is high exactly 4 of every 12 cycles and vs_out is high for exactly 24 cycles per frame.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video constants: BT.656 blanking code, default NTSC 4:2:2 raster
// dimensions, the run-state enum and a counter-width helper.
package video_pkg;

   localparam logic [7:0]  BT656_BLANK   = 8'h10;

   localparam int unsigned NTSC_H_ACTIVE = 1440;
   localparam int unsigned NTSC_H_BLANK  = 276;
   localparam int unsigned NTSC_V_ACTIVE = 480;
   localparam int unsigned NTSC_V_BLANK  = 45;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } run_state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster position generator: horizontal/vertical counters that free-run while
// run_i is high and sit at (0,0) otherwise, plus decoded region flags.
module video_timing_gen
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE = NTSC_H_ACTIVE,
   parameter int unsigned H_BLANK  = NTSC_H_BLANK,
   parameter int unsigned V_ACTIVE = NTSC_V_ACTIVE,
   parameter int unsigned V_BLANK  = NTSC_V_BLANK
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic run_i,
   output logic active_o,
   output logic hblank_o,
   output logic vblank_o,
   output logic frame_end_o
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int unsigned HW      = cnt_width(H_TOTAL);
   localparam int unsigned VW      = cnt_width(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;

   // Next raster position: advance while running, wrap line then frame.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!run_i) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
         h_cnt_d = h_cnt_q + 1'b1;
      end
   end

   // Position counters.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Region decode of the current position.
   always_comb begin
      hblank_o    = (h_cnt_q >= H_ACT);
      vblank_o    = (v_cnt_q >= V_ACT);
      active_o    = !hblank_o && !vblank_o;
      frame_end_o = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
   end

endmodule

// File: rtl/tile_output_buffer.sv
// AXI4-Stream to 8-bit video bus: holds one 32-bit word, unpacks it LSB first
// into the active region of a generated raster, and keeps sticky underflow and
// frame-length status. The raster never stalls; a starved slot emits blanking.
module tile_output_buffer
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = NTSC_H_ACTIVE,
   parameter int unsigned H_BLANK    = NTSC_H_BLANK,
   parameter int unsigned V_ACTIVE   = NTSC_V_ACTIVE,
   parameter int unsigned V_BLANK    = NTSC_V_BLANK,
   parameter logic [7:0]  BLANK_BYTE = BT656_BLANK
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        enable,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [7:0]  data_out,
   output logic        hs_out,
   output logic        vs_out,
   output logic        de_out,
   output logic        underflow,
   output logic        frame_err,
   input  logic        clear_status
);

   localparam int unsigned WPF = (H_ACTIVE * V_ACTIVE) / 4;
   localparam int unsigned WW  = cnt_width(WPF);
   localparam logic [WW-1:0] W_LAST = WW'(WPF - 1);

   run_state_e    state_q, state_d;
   logic          run, tready;
   logic          active, hblank, vblank, frame_end;

   logic [31:0]   word_q, word_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic          word_valid_q, word_valid_d;
   logic [WW-1:0] word_cnt_q, word_cnt_d;
   logic [7:0]    data_q, data_d;
   logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic          uf_q, uf_d, fe_q, fe_d;
   logic          accept, emit, starve;

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_BLANK  (H_BLANK),
      .V_ACTIVE (V_ACTIVE),
      .V_BLANK  (V_BLANK)
   ) u_timing (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .run_i       (run),
      .active_o    (active),
      .hblank_o    (hblank),
      .vblank_o    (vblank),
      .frame_end_o (frame_end)
   );

   // Run-state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Start on enable; only stop at the last position so a frame always completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (enable)                state_d = RUN;
         RUN:  if (frame_end && !enable)  state_d = IDLE;
      endcase
   end

   // Run flag and ready: take a word when empty, or pass-through refill on the last byte.
   always_comb begin
      run    = 1'b0;
      tready = 1'b0;
      if (state_q == RUN) begin
         run    = 1'b1;
         tready = !word_valid_q || (active && (byte_idx_q == 2'd3));
      end
   end

   assign s_axis_tready = tready;
   assign accept        = tready && s_axis_tvalid;
   assign emit          = run && active && word_valid_q;
   assign starve        = run && active && !word_valid_q;

   // Unpacker, word counter, status and registered video outputs.
   always_comb begin
      word_d       = word_q;
      byte_idx_d   = byte_idx_q;
      word_valid_d = word_valid_q;
      word_cnt_d   = word_cnt_q;

      if (emit) begin
         if (byte_idx_q == 2'd3) begin
            byte_idx_d   = 2'd0;
            word_valid_d = 1'b0;
         end else begin
            byte_idx_d   = byte_idx_q + 1'b1;
         end
      end
      if (accept) begin
         word_d       = s_axis_tdata;
         byte_idx_d   = 2'd0;
         word_valid_d = 1'b1;
      end

      if ((state_q == IDLE) && enable)
         word_cnt_d = '0;
      else if (accept)
         word_cnt_d = (word_cnt_q == W_LAST) ? '0 : word_cnt_q + 1'b1;

      data_d = emit ? word_q[8*byte_idx_q +: 8] : BLANK_BYTE;
      de_d   = emit;
      hs_d   = run && hblank;
      vs_d   = run && vblank;

      // Set has priority over a same-cycle clear.
      uf_d = starve ? 1'b1 : (clear_status ? 1'b0 : uf_q);
      fe_d = (accept && (s_axis_tlast != (word_cnt_q == W_LAST))) ? 1'b1
           : (clear_status ? 1'b0 : fe_q);
   end

   // Datapath and output registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         // NOTE: the held word is reset too, so a reset always discards any partially sent word.
         word_q       <= '0;
         byte_idx_q   <= 2'd0;
         word_valid_q <= 1'b0;
         word_cnt_q   <= '0;
         data_q       <= BLANK_BYTE;
         hs_q         <= 1'b0;
         vs_q         <= 1'b0;
         de_q         <= 1'b0;
         uf_q         <= 1'b0;
         fe_q         <= 1'b0;
      end else begin
         word_q       <= word_d;
         byte_idx_q   <= byte_idx_d;
         word_valid_q <= word_valid_d;
         word_cnt_q   <= word_cnt_d;
         data_q       <= data_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         de_q         <= de_d;
         uf_q         <= uf_d;
         fe_q         <= fe_d;
      end
   end

   assign data_out  = data_q;
   assign hs_out    = hs_q;
   assign vs_out    = vs_q;
   assign de_out    = de_q;
   assign underflow = uf_q;
   assign frame_err = fe_q;

endmodule
